// File: rtl/pc_calc.sv
// Program-counter register and next-PC selector for the RV32 pipeline.
// Optional macro PCCALC_JALR_ALIGN_EN clears bit 0 of the JALR redirect target.
module pc_calc #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            stall,
  input  logic            stay,
  input  logic [2:0]      branch_type,
  input  logic            alu_zero,
  input  logic            alu_neg,
  input  logic [XLEN-1:0] pc_with_offset,
  input  logic [XLEN-1:0] target_pc,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] return_pc
);

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_JAL  = 3'd1,
    BR_JALR = 3'd2,
    BR_BEQ  = 3'd3,
    BR_BNE  = 3'd4,
    BR_BLT  = 3'd5,
    BR_BGT  = 3'd6,
    BR_RSVD = 3'd7
  } br_e;

  br_e             br;
  logic            taken;
  logic [XLEN-1:0] jalr_target;
  logic [XLEN-1:0] redirect;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] pc_next;

  assign br = br_e'(branch_type);

  // Branch resolution from the compare flags of rs1-rs2
  always_comb begin
    taken = 1'b0;
    case (br)
      BR_JAL:  taken = 1'b1;
      BR_JALR: taken = 1'b1;
      BR_BEQ:  taken = alu_zero;
      BR_BNE:  taken = ~alu_zero;
      BR_BLT:  taken = alu_neg;
      BR_BGT:  taken = ~alu_neg & ~alu_zero;
      default: taken = 1'b0;
    endcase
  end

`ifdef PCCALC_JALR_ALIGN_EN
  assign jalr_target = {target_pc[XLEN-1:1], 1'b0};
`else
  assign jalr_target = target_pc;
`endif

  assign redirect  = (br == BR_JALR) ? jalr_target : pc_with_offset;
  assign seq_pc    = pc + XLEN'(PC_STEP);
  assign return_pc = seq_pc;

  // Hold beats redirect; redirect beats stall so resolved control flow is never dropped
  always_comb begin
    pc_next = pc;
    if (stay) begin
      pc_next = pc;
    end else if (taken) begin
      pc_next = redirect;
    end else if (stall) begin
      pc_next = pc;
    end else begin
      pc_next = seq_pc;
    end
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

endmodule

// File: tb/tb_pc_calc.sv
// Randomized scoreboard bench for pc_calc with a plain-arithmetic next-PC model.
module tb_pc_calc;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        stall = 1'b0;
  logic        stay = 1'b0;
  logic [2:0]  branch_type = 3'd0;
  logic        alu_zero = 1'b0;
  logic        alu_neg = 1'b0;
  logic [31:0] pc_with_offset = '0;
  logic [31:0] target_pc = '0;
  logic [31:0] pc;
  logic [31:0] return_pc;

  logic        w_stall = 1'b0;
  logic        w_stay = 1'b0;
  logic [2:0]  w_bt = 3'd0;
  logic        w_zero = 1'b0;
  logic        w_neg = 1'b0;
  logic [31:0] w_off = '0;
  logic [31:0] w_tgt = '0;
  logic [31:0] w_pc;
  logic [31:0] w_ret;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mpc;

  always #5 clk = ~clk;

  pc_calc u_dut (
    .clk(clk), .rstn(rstn), .stall(stall), .stay(stay),
    .branch_type(branch_type), .alu_zero(alu_zero), .alu_neg(alu_neg),
    .pc_with_offset(pc_with_offset), .target_pc(target_pc),
    .pc(pc), .return_pc(return_pc)
  );

  pc_calc #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rstn(rstn), .stall(w_stall), .stay(w_stay),
    .branch_type(w_bt), .alu_zero(w_zero), .alu_neg(w_neg),
    .pc_with_offset(w_off), .target_pc(w_tgt),
    .pc(w_pc), .return_pc(w_ret)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference next-PC from the architectural rules
  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [2:0] bt,
                                             input logic z, input logic n,
                                             input logic [31:0] off, input logic [31:0] tgt,
                                             input logic st, input logic sy);
    bit tk;
    logic [31:0] dest;
    case (bt)
      3'd1, 3'd2: tk = 1;
      3'd3: tk = z;
      3'd4: tk = !z;
      3'd5: tk = n;
      3'd6: tk = !n && !z;
      default: tk = 0;
    endcase
`ifdef PCCALC_JALR_ALIGN_EN
    dest = (bt == 3'd2) ? (tgt & 32'hFFFF_FFFE) : off;
`else
    dest = (bt == 3'd2) ? tgt : off;
`endif
    if (sy) return cur;
    if (tk) return dest;
    if (st) return cur;
    return cur + 32'd4;
  endfunction

  // Called just after a negedge: drive one cycle of inputs and queue the expected pc
  task automatic step(input logic [2:0] bt, input logic z, input logic n,
                      input logic [31:0] off, input logic [31:0] tgt,
                      input logic st, input logic sy);
    branch_type = bt; alu_zero = z; alu_neg = n;
    pc_with_offset = off; target_pc = tgt; stall = st; stay = sy;
    mpc = model_next(mpc, bt, z, n, off, tgt, st, sy);
    exp_q.push_back(mpc);
    @(negedge clk);
  endtask

  // Mid-cycle asynchronous reset, released at a negedge
  task automatic do_reset();
    branch_type = 3'd0; stall = 1'b0; stay = 1'b0;
    #2 rstn = 1'b1;
    #1;
    check("async_reset_pc", pc, 32'h0);
    check("async_reset_return_pc", return_pc, 32'h4);
    @(negedge clk);
    @(negedge clk);
    check("reset_held_pc", pc, 32'h0);
    rstn = 1'b0;
    mpc = 32'h0;
  endtask

  // Monitor: the DUT presents a new pc every clock edge out of reset
  initial begin
    logic [31:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pc", pc, e);
        check("return_pc", return_pc, e + 32'd4);
      end
    end
  end

  initial begin
    mpc = 32'h0;
    do_reset();
    check("wrap_reset_return_pc", w_ret, 32'h0);
    step(3'd0, 0, 0, 32'h0, 32'h0, 0, 0);
    check("wrap_pc", w_pc, 32'h0);
    check("wrap_return_pc", w_ret, 32'h4);
    step(3'd0, 0, 0, 32'h0, 32'h0, 0, 0);
    step(3'd0, 0, 0, 32'h0, 32'h0, 0, 0);
    // Branch decode against pc_with_offset = 0xC
    step(3'd1, 0, 0, 32'hC, 32'h0, 0, 0);
    step(3'd3, 1, 0, 32'hC, 32'h0, 0, 0);
    step(3'd4, 1, 0, 32'hC, 32'h0, 0, 0);
    step(3'd5, 0, 1, 32'hC, 32'h0, 0, 0);
    step(3'd6, 0, 1, 32'hC, 32'h0, 0, 0);
    step(3'd6, 0, 0, 32'hC, 32'h0, 0, 0);
    step(3'd6, 1, 1, 32'hC, 32'h0, 0, 0);
    check("jalr_return_before_edge", return_pc, mpc + 32'd4);
    step(3'd2, 0, 0, 32'hC, 32'hAD, 0, 0);
`ifdef PCCALC_JALR_ALIGN_EN
    check("jalr_target", pc, 32'hAC);
`else
    check("jalr_target", pc, 32'hAD);
`endif
    // Stall / stay priority
    step(3'd0, 0, 0, 32'hC, 32'h0, 1, 0);
    step(3'd0, 0, 0, 32'hC, 32'h0, 1, 0);
    step(3'd0, 0, 0, 32'hC, 32'h0, 1, 0);
    step(3'd1, 0, 0, 32'hC, 32'h0, 1, 0);
    step(3'd1, 0, 0, 32'h100, 32'h0, 0, 1);
    step(3'd7, 1, 0, 32'h100, 32'h0, 0, 0);
    // Async reset from pc = 0x40
    step(3'd1, 0, 0, 32'h3C, 32'h0, 0, 0);
    step(3'd0, 0, 0, 32'h0, 32'h0, 0, 0);
    check("pre_reset_pc", pc, 32'h40);
    do_reset();
    step(3'd0, 0, 0, 32'h0, 32'h0, 0, 0);
    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset();
      end
      step(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom, $urandom,
           $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
    end
    @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_calc.md
Name: pc_calc

Overview:
- Program-counter register and next-PC selector for the pipelined RV32 core.
- Resolves branch/jump outcome from the branch type and ALU flags, then picks the next fetch address:
  - sequential PC+4
  - PC-relative target
  - register-indirect target
- Also supplies the link address (PC+4) used by JAL/JALR writeback.

Parameters:
- XLEN, 32, address/data width in bits.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, sequential increment in bytes.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rstn  input  1  reset, asynchronous, active-high. The name is kept for codebase consistency; rstn=1 resets.
- stall  input  1  pipeline stall; blocks sequential advance.
- stay  input  1  hard hold (halt/debug); freezes PC unconditionally.
- branch_type  input  3  jump/branch kind, encoded as:
  - 0 NONE
  - 1 JMP_JAL
  - 2 JMP_JALR
  - 3 JMP_BEQ
  - 4 JMP_BNE
  - 5 JMP_BLT
  - 6 JMP_BGT
  - 7 reserved, treated as NONE
- alu_zero  input  1  ALU result == 0 (compare of rs1-rs2).
- alu_neg  input  1  ALU result negative (rs1 < rs2, signed).
- pc_with_offset  input  XLEN  PC-relative target (pc + imm), used by JAL and conditional branches.
- target_pc  input  XLEN  register-indirect target (rs1 + imm), used by JALR.
- pc  output  XLEN  current PC register.
- return_pc  output  XLEN  link address = pc + PC_STEP (combinational).

Behaviour:
- Reset (rstn=1, asynchronous): pc = RESET_PC immediately, regardless of clk; return_pc = RESET_PC + 4.
- Taken decode (combinational, 1 signal "taken"):
  - NONE/reserved: 0
  - JAL: 1
  - JALR: 1
  - BEQ: alu_zero
  - BNE: ~alu_zero
  - BLT: alu_neg
  - BGT: ~alu_neg & ~alu_zero (strictly greater)
- Redirect target:
  - JALR: target_pc (see Optional Feature)
  - all other taken types: pc_with_offset
- Next-PC priority, evaluated each rising edge with rstn=0:
  1. stay=1: pc holds.
  2. taken=1: pc <= redirect target. A redirect overrides stall so resolved control flow is never lost.
  3. stall=1: pc holds.
  4. otherwise: pc <= pc + PC_STEP.
- Latency: one cycle from inputs to new pc; return_pc tracks pc with zero latency.
- Arithmetic: additions modulo 2^XLEN. 0xFFFF_FFFC + 4 wraps to 0x0000_0000 with no flag.
- alu_zero and alu_neg both 1 is illegal upstream. Decode still follows the equations above, e.g. BGT is not taken.
- No alignment checking on pc_with_offset; value is loaded verbatim.
- Reset asserted mid-operation overrides every other input in the same cycle. On deassertion, pc resumes from RESET_PC at the next edge.

Optional Feature:
- Macro PCCALC_JALR_ALIGN_EN.
- Defined: JALR redirect = target_pc with bit 0 forced to 0, per RISC-V JALR semantics.
- Undefined: JALR redirect = target_pc verbatim.
- Other branch types are unaffected either way.

Test Plan:
- Reset: hold rstn=1 mid-cycle -> pc=0x0 immediately (no clock edge needed), return_pc=0x4. Release with branch_type=0, stall=stay=0 -> pc = 0x4, 0x8, 0xC on successive edges.
- JAL and conditional branches, pc_with_offset=0xC:
  - branch_type=JAL -> next pc=0xC.
  - BEQ with alu_zero=1 -> 0xC.
  - BNE with alu_zero=1 -> not taken, pc+4.
  - alu_zero=0, alu_neg=1: BLT -> 0xC; BGT -> pc+4.
  - alu_zero=0, alu_neg=0: BGT -> 0xC.
- JALR: target_pc=0xAD, branch_type=JALR -> pc=0xAC with PCCALC_JALR_ALIGN_EN, 0xAD without; return_pc = old pc+4 in the cycle before the edge.
- Stall/stay priority:
  - stall=1, branch_type=0 -> pc holds for 3 edges.
  - stall=1, JAL to 0xC -> pc=0xC.
  - stay=1, JAL -> pc holds.
- Wrap: RESET_PC=0xFFFF_FFFC -> after one edge pc=0x0, return_pc=0x4.
- Async reset mid-run: pc=0x40, assert rstn between edges -> pc=0x0 within the same cycle.
